// File: rtl/descriptor_link_pkg.sv
// Shared definitions for the host descriptor link (receiver side and uart_tx counterpart).
package descriptor_link_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        WRITE     = 2'd2
    } module_state;

    localparam int BYTE_W                  = 8;
    localparam int UART_FRAME_BITS         = 10;
    localparam int DEFAULT_CLOCKS_PER_BAUD = 50;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection and framing-error reporting.
//
// state        | meaning
// RX_IDLE      | line high, waiting for a falling edge
// RX_START     | half a bit into the start bit, confirming it is still low
// RX_DATA      | sampling 8 data bits, LSB first
// RX_STOP      | sampling the stop bit
// RX_WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx
    import descriptor_link_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              rx,
    output logic [BYTE_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t         state, state_next;
    logic              rx_meta, rx_sync;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [BYTE_W-1:0] shreg, shreg_next;
    logic              valid_next, err_next;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            valid_o <= valid_next;
            err_o   <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state_next = RX_START;
                    cnt_next   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (!rx_sync) begin
                        state_next   = RX_DATA;
                        cnt_next     = BAUD_LOAD;
                        bit_idx_next = '0;
                    end else begin
                        state_next = RX_IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shreg_next = {rx_sync, shreg[BYTE_W-1:1]};
                    cnt_next   = BAUD_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    if (rx_sync) begin
                        valid_next = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // shreg only moves during data bits, so it is stable when valid_o fires
    assign data_o = shreg;

endmodule

// File: rtl/receive_descriptors.sv
// Receives MSB-first multi-byte words over UART and writes them to sequential BRAM addresses.
//
// state     | meaning
// IDLE      | not armed, incoming bytes ignored
// RECEIVING | assembling a word, dropping partial words on error or timeout
// WRITE     | one-cycle BRAM write of the assembled word
module receive_descriptors
    import descriptor_link_pkg::*;
#(
    parameter int BRAM_LENGTH     = 1000,
    parameter int BIT_DEPTH       = 24,
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int BYTE_TIMEOUT    = 20 * CLOCKS_PER_BAUD
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic                           rx,
    input  logic                           start_in,
    output logic [$clog2(BRAM_LENGTH)-1:0] bram_addr,
    output logic [BIT_DEPTH-1:0]           bram_data,
    output logic                           bram_we,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     err_count,
    output logic [1:0]                     out_state
);

    localparam int ADDR_W = $clog2(BRAM_LENGTH);
    localparam int BYTES  = BIT_DEPTH / BYTE_W;
    localparam int IDX_W  = $clog2(BYTES + 1);
    localparam int TMO_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_LENGTH - 1);
    localparam logic [IDX_W-1:0]  FULL_IDX  = IDX_W'(BYTES);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(BYTE_TIMEOUT - 1);

    module_state          state, state_next;
    logic [BYTE_W-1:0]    rx_data;
    logic                 rx_valid, rx_err;
    logic [BIT_DEPTH-1:0] word;
    logic [IDX_W-1:0]     byte_idx;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 tmo_hit;

    uart_rx #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_rx (
        .clk    (clk),
        .rst_in (rst_in),
        .rx     (rx),
        .data_o (rx_data),
        .valid_o(rx_valid),
        .err_o  (rx_err)
    );

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bram_we    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = RECEIVING;
                end
            end
            RECEIVING: begin
                if (byte_idx == FULL_IDX) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bram_we = 1'b1;
                if (bram_addr == LAST_ADDR) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RECEIVING;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_state = state;

    // tmo_cnt is loaded on every byte and only runs while a word is partially assembled
    assign tmo_hit = (byte_idx != '0) && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            bram_addr <= '0;
            bram_data <= '0;
            word      <= '0;
            byte_idx  <= '0;
            tmo_cnt   <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        bram_addr <= '0;
                        byte_idx  <= '0;
                        tmo_cnt   <= '0;
                        err_count <= '0;
                    end
                end
                RECEIVING: begin
                    if (byte_idx == FULL_IDX) begin
                        bram_data <= word;
                    end else if (rx_valid) begin
                        word     <= BIT_DEPTH'({word, rx_data});
                        byte_idx <= byte_idx + IDX_W'(1);
                        tmo_cnt  <= TMO_LOAD;
                    end else if (rx_err || tmo_hit) begin
                        byte_idx <= '0;
                        tmo_cnt  <= '0;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else if (byte_idx != '0) begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    byte_idx <= '0;
                    tmo_cnt  <= '0;
                    if (bram_addr != LAST_ADDR) begin
                        bram_addr <= bram_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_receive_descriptors.sv
// Directed bench for receive_descriptors: words, full transfer, framing error, timeout, glitch, reset.
module tb_receive_descriptors;

    localparam int BRAM_LENGTH  = 2;
    localparam int BIT_DEPTH    = 24;
    localparam int CPB          = 50;
    localparam int BYTE_TIMEOUT = 20 * CPB;

    logic                           clk = 1'b0;
    logic                           rst_in;
    logic                           rx;
    logic                           start_in;
    logic [$clog2(BRAM_LENGTH)-1:0] bram_addr;
    logic [BIT_DEPTH-1:0]           bram_data;
    logic                           bram_we;
    logic                           busy;
    logic                           done;
    logic [7:0]                     err_count;
    logic [1:0]                     out_state;

    receive_descriptors #(
        .BRAM_LENGTH    (BRAM_LENGTH),
        .BIT_DEPTH      (BIT_DEPTH),
        .CLOCKS_PER_BAUD(CPB),
        .BYTE_TIMEOUT   (BYTE_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .rx       (rx),
        .start_in (start_in),
        .bram_addr(bram_addr),
        .bram_data(bram_data),
        .bram_we  (bram_we),
        .busy     (busy),
        .done     (done),
        .err_count(err_count),
        .out_state(out_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          wr_count    = 0;
    int          valid_count = 0;
    int          rxerr_count = 0;
    logic [31:0] last_addr   = '0;
    logic [31:0] last_data   = '0;
    logic        last_done   = 1'b0;
    logic        last_busy   = 1'b0;
    logic        prev_done   = 1'b0;
    logic        busy_after_done = 1'b1;

    always @(negedge clk) begin
        if (bram_we) begin
            wr_count++;
            last_addr = 32'(bram_addr);
            last_data = 32'(bram_data);
            last_done = done;
            last_busy = busy;
        end
        if (prev_done) busy_after_done = busy;
        prev_done = done;
        if (dut.u_rx.valid_o) valid_count++;
        if (dut.u_rx.err_o) rxerr_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic arm();
        start_in = 1'b1;
        tick(1);
        start_in = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick(3);
        rst_in = 1'b1;
        tick(2);
    endtask

    int v0, e0, w0;

    initial begin
        rx       = 1'b1;
        start_in = 1'b0;
        rst_in   = 1'b0;
        tick(3);
        check_eq("rst_we", 32'(bram_we), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err_count), 0);
        check_eq("rst_state", 32'(out_state), 0);
        check_eq("rst_addr", 32'(bram_addr), 0);
        check_eq("rst_data", 32'(bram_data), 0);
        rst_in = 1'b1;
        tick(2);

        // bytes while idle are dropped
        send_byte(8'h55, 1'b1);
        check_eq("idle_nowrite", 32'(wr_count), 0);
        check_eq("idle_state", 32'(out_state), 0);

        arm();
        check_eq("arm_busy", 32'(busy), 1);
        check_eq("arm_state", 32'(out_state), 1);

        send_word(24'hABCDEF);
        check_eq("w1_count", 32'(wr_count), 1);
        check_eq("w1_addr", last_addr, 0);
        check_eq("w1_data", last_data, 32'h00ABCDEF);
        check_eq("w1_done", 32'(last_done), 0);
        check_eq("w1_busy", 32'(last_busy), 1);
        check_eq("w1_next_addr", 32'(bram_addr), 1);
        check_eq("w1_hold_data", 32'(bram_data), 32'h00ABCDEF);

        // start while busy must not restart the transfer
        arm();
        check_eq("busy_start_addr", 32'(bram_addr), 1);
        busy_after_done = 1'b1;
        send_word(24'h123456);
        check_eq("w2_count", 32'(wr_count), 2);
        check_eq("w2_addr", last_addr, 1);
        check_eq("w2_data", last_data, 32'h00123456);
        check_eq("w2_done", 32'(last_done), 1);
        check_eq("w2_busy_after", 32'(busy_after_done), 0);
        check_eq("w2_state", 32'(out_state), 0);

        // full transfer
        arm();
        check_eq("full_addr0", 32'(bram_addr), 0);
        send_word(24'h000001);
        check_eq("full_count0", 32'(wr_count), 3);
        check_eq("full_wa0", last_addr, 0);
        check_eq("full_wd0", last_data, 32'h00000001);
        check_eq("full_done0", 32'(last_done), 0);
        busy_after_done = 1'b1;
        send_word(24'hFFFFFE);
        check_eq("full_count1", 32'(wr_count), 4);
        check_eq("full_wa1", last_addr, 1);
        check_eq("full_wd1", last_data, 32'h00FFFFFE);
        check_eq("full_done1", 32'(last_done), 1);
        check_eq("full_busy_after", 32'(busy_after_done), 0);
        send_word(24'h777777);
        check_eq("post_done_nowrite", 32'(wr_count), 4);
        check_eq("post_done_addr", 32'(bram_addr), 1);

        // framing error drops the partial word
        arm();
        e0 = rxerr_count;
        send_byte(8'h12, 1'b1);
        send_byte(8'h00, 1'b0);
        check_eq("frm_rxerr", 32'(rxerr_count - e0), 1);
        send_word(24'h345678);
        check_eq("frm_errcnt", 32'(err_count), 1);
        check_eq("frm_count", 32'(wr_count), 5);
        check_eq("frm_addr", last_addr, 0);
        check_eq("frm_data", last_data, 32'h00345678);

        // inter-byte timeout drops the partial word
        do_reset();
        arm();
        send_byte(8'h11, 1'b1);
        tick(BYTE_TIMEOUT + 10);
        check_eq("tmo_errcnt_early", 32'(err_count), 1);
        send_word(24'h223344);
        check_eq("tmo_errcnt", 32'(err_count), 1);
        check_eq("tmo_count", 32'(wr_count), 6);
        check_eq("tmo_addr", last_addr, 0);
        check_eq("tmo_data", last_data, 32'h00223344);

        // async reset mid-word, between clock edges
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        @(posedge clk);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_state", 32'(out_state), 0);
        check_eq("arst_addr", 32'(bram_addr), 0);
        check_eq("arst_data", 32'(bram_data), 0);
        check_eq("arst_err", 32'(err_count), 0);
        check_eq("arst_we", 32'(bram_we), 0);
        tick(2);
        rst_in = 1'b1;
        tick(2);
        check_eq("arst_nowrite", 32'(wr_count), 6);
        arm();
        send_word(24'h9ABCDE);
        check_eq("rearm_count", 32'(wr_count), 7);
        check_eq("rearm_addr", last_addr, 0);
        check_eq("rearm_data", last_data, 32'h009ABCDE);

        // short low pulse on an idle line is not a start bit
        do_reset();
        arm();
        v0 = valid_count;
        e0 = rxerr_count;
        w0 = wr_count;
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(3 * CPB);
        check_eq("glitch_valid", 32'(valid_count - v0), 0);
        check_eq("glitch_rxerr", 32'(rxerr_count - e0), 0);
        check_eq("glitch_errcnt", 32'(err_count), 0);
        send_word(24'h5A0FF0);
        check_eq("glitch_valid_word", 32'(valid_count - v0), 3);
        check_eq("glitch_count", 32'(wr_count - w0), 1);
        check_eq("glitch_addr", last_addr, 0);
        check_eq("glitch_data", last_data, 32'h005A0FF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
